// File: rtl/serial_parity_checker.sv
// Serial frame parity checker: deserialises DATA_BITS bits LSB first, then checks one parity bit.
// A running XOR accumulator tracks parity; start mid-frame aborts and restarts the frame.
module serial_parity_checker #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_ok,
  output logic                 frame_done,
  output logic                 abort
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_BITS - 1);
  localparam logic OddBit = (ODD_PARITY != 0);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 parity_ok_q, parity_ok_d;
  logic                 frame_done_q, frame_done_d;
  logic                 abort_q, abort_d;
  logic                 busy_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    parity_ok_d  = parity_ok_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StData;
          cnt_d   = '0;
          acc_d   = 1'b0;
          shift_d = '0;
        end
      end
      StData: begin
        if (start) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          acc_d   = 1'b0;
          shift_d = '0;
        end else if (bit_valid) begin
          // Right shift so the first bit received ends up in bit 0.
          shift_d = {bit_in, shift_q[DATA_BITS-1:1]};
          acc_d   = acc_q ^ bit_in;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (start) begin
          abort_d = 1'b1;
          state_d = StData;
          cnt_d   = '0;
          acc_d   = 1'b0;
          shift_d = '0;
        end else if (bit_valid) begin
          parity_ok_d  = ((acc_q ^ bit_in ^ OddBit) == 1'b0);
          data_out_d   = shift_q;
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      shift_q      <= '0;
      data_out_q   <= '0;
      parity_ok_q  <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      parity_ok_q  <= parity_ok_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign parity_ok  = parity_ok_q;
  assign frame_done = frame_done_q;
  assign abort      = abort_q;

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Serial-frame parity checker that sits directly downstream of the three-input XOR gate. The XOR stage is reused here as a running parity accumulator, one incoming bit per cycle. The block deserialises DATA_BITS data bits (LSB first), then samples one parity bit and reports the recovered word together with a pass/fail flag. It feeds the lab's status LEDs and the scoreboard in later labs.

Parameters:
DATA_BITS, 8, number of data bits per frame (legal range 2..32)
ODD_PARITY, 0, 0 = even parity (total ones including parity bit is even); 1 = odd parity

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle frame-start strobe
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in is valid this cycle
busy  output  1  high while a frame is in progress (DATA or PARITY state)
data_out  output  DATA_BITS  last completed frame's data word, held between frames
parity_ok  output  1  result for the last completed frame, held between frames
frame_done  output  1  one-cycle pulse when data_out/parity_ok update
abort  output  1  one-cycle pulse when a frame in progress is discarded by start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, data_out=0, parity_ok=0, frame_done=0, abort=0; shift register, bit counter and parity accumulator all cleared. Outputs stay at these values until rst_n deasserts.
- All state and outputs are registered on the rising edge of clk; there are no combinational paths from inputs to outputs.
- States: IDLE, DATA, PARITY.
- IDLE:
  - bit_valid is ignored.
  - start=1 -> go to DATA; clear counter, accumulator and shift register.
  - A bit_valid arriving in the same cycle as start is not sampled; the first data bit is taken from the next cycle.
- DATA:
  - Each cycle with bit_valid=1: shift bit_in into the word LSB first (first bit received lands in bit 0); acc <= acc ^ bit_in; cnt <= cnt+1.
  - When the DATA_BITS-th bit is sampled -> go to PARITY.
  - Cycles with bit_valid=0 hold all state; gaps of any length are allowed.
- PARITY:
  - On bit_valid=1: total = acc ^ bit_in ^ ODD_PARITY; parity_ok <= (total==0).
  - In the same edge: data_out <= assembled word, frame_done <= 1 for exactly one cycle, next state IDLE.
  - Result is visible 1 cycle after the parity bit is sampled.
- busy=1 in DATA and PARITY, 0 in IDLE (registered; tracks state).
- start while in DATA or PARITY:
  - The current frame is discarded; abort pulses for 1 cycle; counter, accumulator and shift register are cleared; state goes to DATA (restart).
  - data_out and parity_ok keep their previous values; no frame_done pulse.
  - start takes priority over a simultaneous bit_valid (that bit is dropped).
  - start arriving in the same cycle the parity bit is sampled aborts that frame; no frame_done.
- start in IDLE does not pulse abort.
- Counter width = clog2(DATA_BITS+1). The counter never wraps within a frame, because the state changes at count DATA_BITS.
- rst_n asserted mid-frame: immediate return to the reset values; the partial frame is lost and no frame_done or abort pulse is produced.
- frame_done and abort are never high in the same cycle.

Test Plan:
- Even parity, DATA_BITS=8: start, then bits 1,0,1,0,0,1,0,1 (0xA5), parity 0, all back-to-back -> frame_done pulses 1 cycle after parity bit, data_out=0xA5, parity_ok=1; busy high for exactly 9 cycles.
- Same frame with parity bit 1 -> data_out=0xA5, parity_ok=0; then frame 0x00 with parity 0 -> parity_ok=1, data_out=0x00.
- ODD_PARITY=1: frame 0x07 with parity 0 -> parity_ok=1; 0x07 with parity 1 -> parity_ok=0.
- Gaps: 0x3C delivered with bit_valid low for 1-3 random cycles between bits -> data_out=0x3C, parity_ok=1 with parity 0; frame_done width 1.
- Restart: start, 4 bits, start again -> abort pulses once, previous data_out unchanged, no frame_done; the new full frame 0x81/parity 0 completes -> data_out=0x81, parity_ok=1. Simultaneous start+bit_valid in IDLE -> that bit is not counted.
- Reset mid-frame: rst_n low after 5 data bits -> busy, data_out, parity_ok, frame_done all 0 immediately (asynchronous, before the next clk edge); a full subsequent frame 0x5A/parity 0 -> parity_ok=1.
